// File: rtl/lib_cpu_pkg.sv
// Shared definitions for the 4-bit CPU: opcode encodings, the decoded
// operation kinds, the instruction byte layout and the opcode decoder.
package lib_cpu;

  // Raw opcode encodings, taken from the upper nibble of a program byte.
  localparam logic [3:0] OPC_ADD_A_IMM = 4'b0000;
  localparam logic [3:0] OPC_MOV_A_B   = 4'b0001;
  localparam logic [3:0] OPC_IN_A      = 4'b0010;
  localparam logic [3:0] OPC_MOV_A_IMM = 4'b0011;
  localparam logic [3:0] OPC_MOV_B_A   = 4'b0100;
  localparam logic [3:0] OPC_ADD_B_IMM = 4'b0101;
  localparam logic [3:0] OPC_IN_B      = 4'b0110;
  localparam logic [3:0] OPC_MOV_B_IMM = 4'b0111;
  localparam logic [3:0] OPC_OUT_B     = 4'b1001;
  localparam logic [3:0] OPC_OUT_IMM   = 4'b1011;
  localparam logic [3:0] OPC_JNC_IMM   = 4'b1110;
  localparam logic [3:0] OPC_JMP_IMM   = 4'b1111;

  // Operation kinds handed to the execute stage.
  typedef enum logic [3:0] {
    OP_NOP        = 4'd0,
    OP_ADD_A_IMM  = 4'd1,
    OP_MOV_A_B    = 4'd2,
    OP_IN_A       = 4'd3,
    OP_MOV_A_IMM  = 4'd4,
    OP_MOV_B_A    = 4'd5,
    OP_ADD_B_IMM  = 4'd6,
    OP_IN_B       = 4'd7,
    OP_MOV_B_IMM  = 4'd8,
    OP_OUT_B      = 4'd9,
    OP_OUT_IMM    = 4'd10,
    OP_JNC_IMM    = 4'd11,
    OP_JMP_IMM    = 4'd12
  } OP_KIND;

  // Program byte layout: opcode in the high nibble, immediate in the low.
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] imm;
  } INSTR;

  // Decoder result: operation kind plus a flag for undefined opcodes.
  typedef struct packed {
    OP_KIND op;
    logic   illegal;
  } DECODED;

  // Maps an instruction to its operation kind; undefined opcodes give NOP.
  function automatic DECODED decode(input INSTR instr);
    DECODED d;
    d.op      = OP_NOP;
    d.illegal = 1'b0;
    case (instr.opcode)
      OPC_ADD_A_IMM: d.op = OP_ADD_A_IMM;
      OPC_MOV_A_B:   d.op = OP_MOV_A_B;
      OPC_IN_A:      d.op = OP_IN_A;
      OPC_MOV_A_IMM: d.op = OP_MOV_A_IMM;
      OPC_MOV_B_A:   d.op = OP_MOV_B_A;
      OPC_ADD_B_IMM: d.op = OP_ADD_B_IMM;
      OPC_IN_B:      d.op = OP_IN_B;
      OPC_MOV_B_IMM: d.op = OP_MOV_B_IMM;
      OPC_OUT_B:     d.op = OP_OUT_B;
      OPC_OUT_IMM:   d.op = OP_OUT_IMM;
      OPC_JNC_IMM:   d.op = OP_JNC_IMM;
      OPC_JMP_IMM:   d.op = OP_JMP_IMM;
      default:       d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/prog_mem16x8.sv
// 16x8 program RAM: one write port, one synchronous read port, no reset.
module prog_mem16x8 (
  input  logic       clk,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic       re,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [16];

  // Write port and registered read port; rdata holds between reads.
  // NOTE: the array has no reset so the program survives rst_n and maps onto RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/td4_fetch_decode.sv
// Fetch/decode front end of the 4-bit CPU: fetches mem[ip], decodes it and
// offers it to the execute stage over a valid/ready handshake.
module td4_fetch_decode
  import lib_cpu::*;
#(
  parameter int CNT_W        = 8,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [3:0]       ip,
  input  logic             prog_we,
  input  logic [3:0]       prog_addr,
  input  logic [7:0]       prog_data,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [3:0]       issue_op,
  output logic [3:0]       issue_imm,
  output logic             illegal_seen,
  output logic             busy,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] DECODE = 2'd2;
  localparam logic [1:0] ISSUE  = 2'd3;

  logic [1:0] state;
  logic       halt_lock;
  logic [7:0] rd_data;
  INSTR       instr;
  DECODED     dec;
  logic       accept;

  // The RAM read register doubles as the instruction register; it is only
  // reloaded in FETCH so it stays stable through DECODE.
  prog_mem16x8 u_mem (
    .clk   (clk),
    .we    (prog_we && (state == IDLE)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (state == FETCH),
    .raddr (ip),
    .rdata (rd_data)
  );

  assign instr  = INSTR'(rd_data);
  assign dec    = decode(instr);
  assign accept = issue_valid && issue_ready;
  assign busy   = (state != IDLE);

  // Control FSM, issue registers, sticky illegal flag and retire counter.
  // NOTE: sequential state uses <= only, so later assignments in the same
  // cycle (halt_lock set in DECODE) override earlier defaults cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      halt_lock    <= 1'b0;
      issue_valid  <= 1'b0;
      issue_op     <= OP_NOP;
      issue_imm    <= 4'd0;
      illegal_seen <= 1'b0;
      retired_cnt  <= '0;
    end else begin
      if (!run) halt_lock <= 1'b0;
      case (state)
        IDLE: begin
          if (prog_we) illegal_seen <= 1'b0;
          if (run && !halt_lock) state <= FETCH;
        end
        FETCH: state <= DECODE;
        DECODE: begin
          if (dec.illegal) illegal_seen <= 1'b1;
          if (dec.illegal && ILLEGAL_HALT) begin
            halt_lock <= 1'b1;
            state     <= IDLE;
          end else begin
            issue_op    <= dec.op;
            issue_imm   <= instr.imm;
            issue_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (accept) begin
            issue_valid <= 1'b0;
            retired_cnt <= retired_cnt + CNT_W'(1);
            state       <= run ? FETCH : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
